// File: rtl/aes_round_pkg.sv
// Shared definitions for the AES round stage.
//   AES_W / WORD_W : state and column widths
//   TAG_MAX_W      : storage width of the channel tag inside a FIFO entry
//   round_entry_t  : one buffered round result {state, tag, fin}
//   tag_w()        : tag port width for a given channel count (min 1)
//   xtime/gf_mul/sbox : GF(2^8) helpers used by the lookup modules
package aes_round_pkg;

  localparam int AES_W     = 128;
  localparam int WORD_W    = 32;
  localparam int TAG_MAX_W = 8;

  typedef struct packed {
    logic [AES_W-1:0]     state;
    logic [TAG_MAX_W-1:0] tag;
    logic                 fin;
  } round_entry_t;

  function automatic int tag_w(input int ch);
    if (ch <= 2) return 1;
    return $clog2(ch);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/S4.sv
// Registered S-box of four bytes in parallel.
//   clk : clock
//   in  : four input bytes
//   out : S-box of each byte, valid one cycle after in
module S4
  import aes_round_pkg::*;
(
  input  logic              clk,
  input  logic [WORD_W-1:0] in,
  output logic [WORD_W-1:0] out
);

  always_ff @(posedge clk) begin
    out <= {sbox(in[31:24]), sbox(in[23:16]), sbox(in[15:8]), sbox(in[7:0])};
  end

endmodule

// File: rtl/aes_round_fifo.sv
// Output FIFO of round results, DEPTH entries, any DEPTH >= 1.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push_i     : write entry_i (accepted when not full, or full with pop_i)
//   pop_i      : drop head (ignored when empty)
//   head_o     : head entry, all zero when empty
//   valid_o    : FIFO non-empty
//   count_o    : number of stored entries
module aes_round_fifo
  import aes_round_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  round_entry_t entry_i,
  input  logic         pop_i,
  output round_entry_t head_o,
  output logic         valid_o,
  output logic [CNT_W-1:0] count_o
);

  round_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic             full;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through valid_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/table_lookup.sv
// Registered T-table lookup of one 32-bit column.
//   clk   : clock
//   state : column, byte b0 = [31:24]
//   p0..p3: T0(b0), T1(b1), T2(b2), T3(b3), valid one cycle after state
module table_lookup
  import aes_round_pkg::*;
(
  input  logic              clk,
  input  logic [WORD_W-1:0] state,
  output logic [WORD_W-1:0] p0,
  output logic [WORD_W-1:0] p1,
  output logic [WORD_W-1:0] p2,
  output logic [WORD_W-1:0] p3
);

  // T0(b) = {2S, S, S, 3S}; T1..T3 are byte rotations of T0.
  function automatic logic [WORD_W-1:0] t0(input logic [7:0] b);
    logic [7:0] s;
    s = sbox(b);
    return {xtime(s), s, s, xtime(s) ^ s};
  endfunction

  logic [WORD_W-1:0] t_b1;
  logic [WORD_W-1:0] t_b2;
  logic [WORD_W-1:0] t_b3;

  assign t_b1 = t0(state[23:16]);
  assign t_b2 = t0(state[15:8]);
  assign t_b3 = t0(state[7:0]);

  always_ff @(posedge clk) begin
    p0 <= t0(state[31:24]);
    p1 <= {t_b1[7:0],  t_b1[31:8]};
    p2 <= {t_b2[15:0], t_b2[31:16]};
    p3 <= {t_b3[23:0], t_b3[31:24]};
  end

endmodule

// File: rtl/aes_round_stage.sv
// Handshaked AES round stage: full round or final round per transaction,
// two-stage pipeline into an output FIFO, with per-channel sticky done flags.
//   clk, reset          : clock, async active-low reset
//   in_valid/in_ready   : input handshake; in_state/in_key/in_final/in_tag payload
//   out_valid/out_ready : output handshake on FIFO head; out_state/out_tag/out_final
//   done_flag           : set when a final-round result of channel t is popped
//   done_clr            : per-channel clear (set wins on collision)
module aes_round_stage
  import aes_round_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int DEPTH = 4,
  localparam int TAG_W = tag_w(CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AES_W-1:0] in_state,
  input  logic [AES_W-1:0] in_key,
  input  logic             in_final,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AES_W-1:0] out_state,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_final,
  output logic [CH-1:0]    done_flag,
  input  logic [CH-1:0]    done_clr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  round_entry_t     push_entry;
  round_entry_t     head;

  logic             s1_valid_q, s1_valid_d;
  logic [AES_W-1:0] key_q;
  logic             fin_q;
  logic [TAG_W-1:0] tag_q;

  logic [3:0][3:0][WORD_W-1:0] tp;   // tp[column][byte]
  logic [3:0][WORD_W-1:0]      sb;
  logic [AES_W-1:0]            result;

  logic [CH-1:0] done_q, done_d;
  logic [CH-1:0] done_set;

  // Credit check: the result in stage 1 already owns a FIFO slot, so a
  // push can never find the FIFO full. Held low while reset is asserted.
  assign in_ready = reset &&
                    (({1'b0, fifo_count} + (CNT_W + 1)'(s1_valid_q)) < (CNT_W + 1)'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign s1_valid_d = accept;

  for (genvar c = 0; c < 4; c++) begin : g_col
    table_lookup u_tl (
      .clk   (clk),
      .state (in_state[AES_W-1-WORD_W*c -: WORD_W]),
      .p0    (tp[c][0]),
      .p1    (tp[c][1]),
      .p2    (tp[c][2]),
      .p3    (tp[c][3])
    );
    S4 u_s4 (
      .clk (clk),
      .in  (in_state[AES_W-1-WORD_W*c -: WORD_W]),
      .out (sb[c])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      key_q      <= '0;
      fin_q      <= 1'b0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        key_q <= in_key;
        fin_q <= in_final;
        tag_q <= in_tag;
      end
    end
  end

  // Column c draws byte r from column c+r (ShiftRows folded into indexing).
  always_comb begin
    logic [WORD_W-1:0] full_w;
    logic [WORD_W-1:0] fin_w;
    result = '0;
    for (int c = 0; c < 4; c++) begin
      full_w = tp[c][0] ^ tp[(c+1)%4][1] ^ tp[(c+2)%4][2] ^ tp[(c+3)%4][3];
      fin_w  = {sb[c][31:24], sb[(c+1)%4][23:16], sb[(c+2)%4][15:8], sb[(c+3)%4][7:0]};
      result[AES_W-1-WORD_W*c -: WORD_W] = (fin_q ? fin_w : full_w) ^ key_q[AES_W-1-WORD_W*c -: WORD_W];
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.state = result;
    push_entry.tag   = TAG_MAX_W'(tag_q);
    push_entry.fin   = fin_q;
  end

  aes_round_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (s1_valid_q),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign pop       = out_valid && out_ready;
  assign out_state = head.state;
  assign out_tag   = head.tag[TAG_W-1:0];
  assign out_final = head.fin;

  // Full tag compared so out-of-range tags never set a flag.
  always_comb begin
    done_set = '0;
    for (int t = 0; t < CH; t++) begin
      if (pop && head.fin && (head.tag == TAG_MAX_W'(t))) done_set[t] = 1'b1;
    end
    done_d = (done_q & ~done_clr) | done_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= '0;
    else        done_q <= done_d;
  end

  assign done_flag = done_q;

endmodule
